// File: rtl/elastic_pipe_pkg.sv
// Shared constants and helpers for the elastic valid/ready pipeline.
// Optional occupancy output is enabled with ELASTIC_PIPE_OCCUPANCY_EN.
package elastic_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Enough bits to count from 0 up to and including depth.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One pipeline stage: a valid bit plus payload register that loads its
// predecessor whenever it is empty or its successor can take its item.
module elastic_pipe_stage
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             next_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic load;

  assign load = !valid || next_ready;

  // Payload only moves on load, so a stalled valid item is never disturbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= in_valid;
      end
      if (load) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe_with_valid.sv
// DEPTH-stage elastic pipeline with valid/ready handshakes and bubble collapse.
// Define ELASTIC_PIPE_OCCUPANCY_EN to add a registered occupancy output.
module elastic_pipe_with_valid
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] feed_valid;
  logic [DEPTH-1:0] next_ready;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [WIDTH-1:0] feed_data  [DEPTH];
  logic             chain_ready;

  // Ready ripples from the output back toward the input; a running variable
  // keeps the chain free of self-referencing vector bits.
  always_comb begin
    chain_ready = down_ready;
    next_ready  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      next_ready[i] = chain_ready;
      chain_ready   = !stage_valid[i] || chain_ready;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign feed_valid[i] = up_valid;
      assign feed_data[i]  = up_data;
    end else begin : g_body
      assign feed_valid[i] = stage_valid[i-1];
      assign feed_data[i]  = stage_data[i-1];
    end

    elastic_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (feed_valid[i]),
      .in_data   (feed_data[i]),
      .next_ready(next_ready[i]),
      .valid     (stage_valid[i]),
      .data      (stage_data[i])
    );
  end

  // Flush blocks both handshakes for the cycle it is asserted.
  assign up_ready   = chain_ready && !flush;
  assign down_valid = stage_valid[DEPTH-1] && !flush;
  assign down_data  = stage_data[DEPTH-1];

`ifdef ELASTIC_PIPE_OCCUPANCY_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic accept;
  logic deliver;

  assign accept  = up_valid && up_ready;
  assign deliver = down_valid && down_ready;

  // Items are conserved, so tracking accepts minus deliveries equals the
  // number of valid stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (accept && !deliver) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (deliver && !accept) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end
`endif

endmodule
